// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder_if
//  Description : Core-to-data-memory bus. The core (master) drives a request
//                tuple and holds it until d_data_valid; the memory (slave)
//                returns registered read data and a completion flag.
//  Signals     : d_address      [31:0] byte address, bits [1:0] ignored
//                d_data_write   [31:0] write data
//                d_data_wstrb   [3:0]  byte-lane enables for writes
//                d_write_enable        1 = write, 0 = read
//                d_data_read    [31:0] registered read / write-back data
//                d_data_valid          access complete
//  Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_responder_if;
    logic [31:0] d_address;
    logic [31:0] d_data_write;
    logic [3:0]  d_data_wstrb;
    logic        d_write_enable;
    logic [31:0] d_data_read;
    logic        d_data_valid;

    modport master (
        output d_address,
        output d_data_write,
        output d_data_wstrb,
        output d_write_enable,
        input  d_data_read,
        input  d_data_valid
    );

    modport slave (
        input  d_address,
        input  d_data_write,
        input  d_data_wstrb,
        input  d_write_enable,
        output d_data_read,
        output d_data_valid
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder
//  Description : Word-organised data RAM with a fixed wait-state latency and
//                byte-strobe writes. A request is accepted whenever the held
//                request tuple differs from the captured one (or the block is
//                idle); the access is performed on the edge that enters DONE
//                and d_data_valid stays high until the request changes.
//  Ports       : clk    rising-edge clock
//                reset  asynchronous, active-high; clears control state only
//                bus    data_mem_responder_if.slave (request in, response out)
//  Parameters  : DEPTH_WORDS  number of 32-bit words (power of two, >= 2)
//                LATENCY      cycles from new request to valid (>= 1)
//                BASE_ADDR    byte address of word 0
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);

    localparam int          c_idx_w     = $clog2(DEPTH_WORDS);
    localparam int          c_cnt_w     = $clog2(LATENCY + 1);
    localparam int          c_req_w     = 30 + 1 + 4 + 32;
    localparam logic [29:0] c_base_word = BASE_ADDR[31:2];
    localparam bit          c_single    = (LATENCY == 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_req_w-1:0]   r_req;
    logic [31:0]          r_rdata;
    logic                 r_valid;
    logic [31:0]          r_mem [DEPTH_WORDS];

    logic [c_req_w-1:0]   w_req;
    logic                 w_new;
    logic [29:0]          w_word_off;
    logic                 w_in_range;
    logic [c_idx_w-1:0]   w_index;
    logic [31:0]          w_cur;
    logic [31:0]          w_merged;
    logic [31:0]          w_rdata_next;
    logic                 w_access;
    logic                 w_commit;

    assign w_req = {bus.d_address[31:2], bus.d_write_enable,
                    bus.d_data_wstrb, bus.d_data_write};

    // Any difference in the held tuple means the core moved on: restart.
    assign w_new = (r_state == ST_IDLE) || (w_req != r_req);

    // Word offset from the base; wrap-around below the base lands in the
    // upper bits and is therefore treated as out of range.
    assign w_word_off = bus.d_address[31:2] - c_base_word;
    assign w_in_range = (w_word_off[29:c_idx_w] == '0);
    assign w_index    = w_word_off[c_idx_w-1:0];
    assign w_cur      = w_in_range ? r_mem[w_index] : 32'h0;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign w_merged[8*i +: 8] = bus.d_data_wstrb[i] ? bus.d_data_write[8*i +: 8]
                                                        : w_cur[8*i +: 8];
    end

    // Out-of-range writes are dropped, so their readback is the (zero) word.
    assign w_rdata_next = (bus.d_write_enable && w_in_range) ? w_merged : w_cur;

    // The access happens on the edge that enters DONE: either a fresh request
    // with single-cycle latency, or the last wait cycle of an unchanged one.
    assign w_access = w_new ? c_single
                            : ((r_state == ST_WAIT) && (r_cnt == c_cnt_w'(1)));

    assign w_commit = w_access && bus.d_write_enable && w_in_range;

    // RAM contents survive reset; a write is suppressed while reset is high
    // so an aborted access can never land.
    always_ff @(posedge clk) begin
        if (w_commit && !reset) begin
            r_mem[w_index] <= w_merged;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_req   <= '0;
            r_rdata <= 32'h0;
            r_valid <= 1'b0;
        end else if (w_access) begin
            r_req   <= w_req;
            r_cnt   <= '0;
            r_state <= ST_DONE;
            r_rdata <= w_rdata_next;
            r_valid <= 1'b1;
        end else if (w_new) begin
            r_req   <= w_req;
            r_cnt   <= c_cnt_w'(LATENCY - 1);
            r_state <= ST_WAIT;
            r_valid <= 1'b0;
        end else if (r_state == ST_WAIT) begin
            r_cnt   <= r_cnt - c_cnt_w'(1);
        end
    end

    assign bus.d_data_read  = r_rdata;
    assign bus.d_data_valid = r_valid;

endmodule
`default_nettype wire
